// File: rtl/rtc_countdown_timer.sv
// Down-counting BCD MM:SS timer: load a preset, decrement once per enable strobe
// while running, flag expiry at 00:00 with a level (done) and a one-cycle pulse (expired).
module rtc_countdown_timer #(
  parameter int MAX_MIN_T = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clear,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] ld_min_t,
  input  logic [3:0] ld_min_u,
  input  logic [3:0] ld_sec_t,
  input  logic [3:0] ld_sec_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam logic [3:0] LP_MAX_MT = 4'(MAX_MIN_T);

  typedef enum logic [1:0] {S_IDLE, S_PAUSE, S_RUN, S_DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_min_t, r_min_u, r_sec_t, r_sec_u;
  logic [3:0] w_min_t_nxt, w_min_u_nxt, w_sec_t_nxt, w_sec_u_nxt;
  logic       r_expired, w_expired_nxt;

  // Saturated preset digits
  logic [3:0] w_sat_min_t, w_sat_min_u, w_sat_sec_t, w_sat_sec_u;
  logic       w_ld_zero;

  assign w_sat_min_t = (ld_min_t > LP_MAX_MT) ? LP_MAX_MT : ld_min_t;
  assign w_sat_min_u = (ld_min_u > 4'd9)      ? 4'd9      : ld_min_u;
  assign w_sat_sec_t = (ld_sec_t > 4'd5)      ? 4'd5      : ld_sec_t;
  assign w_sat_sec_u = (ld_sec_u > 4'd9)      ? 4'd9      : ld_sec_u;
  assign w_ld_zero   = ({w_sat_min_t, w_sat_min_u, w_sat_sec_t, w_sat_sec_u} == 16'h0000);

  // One-second BCD decrement with borrow ripple from seconds units upward
  logic       w_bor_su, w_bor_st, w_bor_mu, w_last;
  logic [3:0] w_dec_min_t, w_dec_min_u, w_dec_sec_t, w_dec_sec_u;

  assign w_bor_su    = (r_sec_u == 4'd0);
  assign w_dec_sec_u = w_bor_su ? 4'd9 : r_sec_u - 4'd1;
  assign w_bor_st    = w_bor_su && (r_sec_t == 4'd0);
  assign w_dec_sec_t = !w_bor_su ? r_sec_t : (r_sec_t == 4'd0) ? 4'd5 : r_sec_t - 4'd1;
  assign w_bor_mu    = w_bor_st && (r_min_u == 4'd0);
  assign w_dec_min_u = !w_bor_st ? r_min_u : (r_min_u == 4'd0) ? 4'd9 : r_min_u - 4'd1;
  assign w_dec_min_t = w_bor_mu ? r_min_t - 4'd1 : r_min_t;
  assign w_last      = ({r_min_t, r_min_u, r_sec_t, r_sec_u} == 16'h0001);

  // A command only pre-empts lower-priority ones when it applies in the current state
  always_comb begin
    w_state_nxt   = r_state;
    w_min_t_nxt   = r_min_t;
    w_min_u_nxt   = r_min_u;
    w_sec_t_nxt   = r_sec_t;
    w_sec_u_nxt   = r_sec_u;
    w_expired_nxt = 1'b0;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_min_t_nxt = 4'd0;
      w_min_u_nxt = 4'd0;
      w_sec_t_nxt = 4'd0;
      w_sec_u_nxt = 4'd0;
    end else if (load) begin
      w_state_nxt = w_ld_zero ? S_IDLE : S_PAUSE;
      w_min_t_nxt = w_sat_min_t;
      w_min_u_nxt = w_sat_min_u;
      w_sec_t_nxt = w_sat_sec_t;
      w_sec_u_nxt = w_sat_sec_u;
    end else if (stop && r_state == S_RUN) begin
      w_state_nxt = S_PAUSE;
    end else if (start && r_state == S_PAUSE) begin
      w_state_nxt = S_RUN;
    end else if (en && r_state == S_RUN) begin
      w_min_t_nxt = w_dec_min_t;
      w_min_u_nxt = w_dec_min_u;
      w_sec_t_nxt = w_dec_sec_t;
      w_sec_u_nxt = w_dec_sec_u;
      if (w_last) begin
        w_state_nxt   = S_DONE;
        w_expired_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_min_t   <= 4'd0;
      r_min_u   <= 4'd0;
      r_sec_t   <= 4'd0;
      r_sec_u   <= 4'd0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_min_t   <= w_min_t_nxt;
      r_min_u   <= w_min_u_nxt;
      r_sec_t   <= w_sec_t_nxt;
      r_sec_u   <= w_sec_u_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  assign min_t   = r_min_t;
  assign min_u   = r_min_u;
  assign sec_t   = r_sec_t;
  assign sec_u   = r_sec_u;
  assign running = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign expired = r_expired;

endmodule
